// File: rtl/mult_ctrl.sv
// mult_ctrl: sequencing and stall controller for the shift-and-add multiplier.
// Issues the start pulse, lends the E-stage ALU to the multiplier while it
// runs, freezes F/D and bubbles E, then pulses HiLoValid when HI/LO are ready.
module mult_ctrl #(
    parameter int unsigned LATENCY = 34
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MultReqE,
    input  logic        MultSgnE,
    input  logic        FlushEIn,
    input  logic [31:0] SrcAE,
    input  logic [31:0] SrcBE,
    input  logic [31:0] MultALU_A,
    input  logic [31:0] MultALU_B,
    output logic        MultE,
    output logic        MultSgn,
    output logic [31:0] ALUInA,
    output logic [31:0] ALUInB,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushE,
    output logic        Busy,
    output logic        HiLoValid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0] LAST_RUN = 6'(LATENCY - 1);

    state_t     state;
    logic [5:0] cnt;
    logic       start;

    // start condition is evaluated in the IDLE cycle itself (cycle T)
    always_comb begin
        start = (state == IDLE) && MultReqE && !FlushEIn && !rst;
    end

    // state register and run counter; completion is defined purely by cnt
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        cnt   <= 6'd1;
                    end
                end
                RUN: begin
                    cnt <= cnt + 6'd1;
                    if (cnt == LAST_RUN) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // output decode; reset forces all control outputs low and passes operands
    always_comb begin
        MultE     = 1'b0;
        MultSgn   = 1'b0;
        ALUInA    = SrcAE;
        ALUInB    = SrcBE;
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushE    = 1'b0;
        Busy      = 1'b0;
        HiLoValid = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    FlushE = FlushEIn;
                    if (start) begin
                        MultE   = 1'b1;
                        MultSgn = MultSgnE;
                        StallF  = 1'b1;
                        StallD  = 1'b1;
                        FlushE  = 1'b1;
                    end
                end
                RUN: begin
                    ALUInA = MultALU_A;
                    ALUInB = MultALU_B;
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                    Busy   = 1'b1;
                end
                DONE: begin
                    HiLoValid = 1'b1;
                    Busy      = 1'b1;
                end
                default: begin
                    FlushE = FlushEIn;
                end
            endcase
        end
    end

endmodule
